// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared types and constants for the UART blocks. The transmitter state
// encoding lives here, so a future receiver or a debug probe can decode the
// same enum.
//
// Contents:
//   uart_tx_state_t  transmitter FSM states (PARITY is only reachable when the
//                    design is built with UART_TX_PARITY_EN)
//   DATA_BITS        payload bits per frame, equal to the byte FIFO width
//   UART_IDLE_LEVEL  level of the serial line between frames (mark)
//   even_parity()    even-parity bit of one payload word
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS       = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Even parity: the returned bit makes the total count of ones (data plus
  // parity) even, which is simply the XOR of the data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage : uart_pkg

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//
// Bit-period timer shared by the UART transmitter and (later) the receiver.
// A counter runs 0..CLKS_PER_BIT-1 and wraps; tick marks the last cycle of
// every bit period. Holding clear keeps the counter at 0, so the first bit
// period after clear is released is a full CLKS_PER_BIT cycles long.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   clear  in   hold the counter at 0 (synchronous)
//   tick   out  one-cycle pulse on the final cycle of each bit period
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  // A value of 1 would need a zero-width counter; keep at least one bit so
  // the declaration stays legal even for out-of-range settings.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Decoded from the counter register alone, so it is stable for the whole
  // cycle it is asserted in.
  assign tick = (cnt == CNT_LAST);

endmodule : baud_tick_gen

// File: rtl/uart_tx_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_drain
//
// Drains bytes from the byte FIFO's read port and sends each one as a UART
// frame (start bit, 8 data bits LSB first, optional even parity, one stop
// bit) on the tx pin.
//
// The FIFO read port has one cycle of registered latency: the strobe goes out
// in FETCH and the byte is captured in LOAD, one edge later. Because the
// strobe is a pure decode of the FETCH state, exactly one read is issued per
// frame, and FETCH is only entered after fifo_empty was seen low in IDLE.
//
// Compile-time option:
//   UART_TX_PARITY_EN  when defined, inserts a PARITY bit period (even parity
//                      of the 8 data bits) between DATA and STOP; the frame
//                      grows from 10 to 11 bit periods. When undefined no
//                      parity state or logic is built.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active-high
//   enable        in   permits starting a new frame (a running frame always
//                      completes)
//   fifo_empty    in   FIFO empty flag
//   fifo_rd_data  in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    out  FIFO read strobe, one pulse per frame
//   tx            out  serial line (registered), idles high
//   busy          out  high whenever the FSM is not in IDLE
//   tx_done       out  one-cycle pulse on the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

  uart_tx_state_t         state;
  uart_tx_state_t         state_next;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_next;
  logic                   tx_q;
  logic                   tx_next;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
  logic                   parity_next;
`endif

  logic                   baud_clear;
  logic                   baud_tick;

  // ---------------------------------------------------------------------------
  // Bit-period timer. It is held cleared outside the bit-carrying states, so
  // it sits at 0 on the first START cycle and every bit period, including
  // START, lasts exactly CLKS_PER_BIT cycles.
  // ---------------------------------------------------------------------------
  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // tx is registered from the *next* state and shift values, so the pin
  // changes on the same edge as the FSM and is glitch-free. A reset anywhere
  // in a frame returns the line to idle on that edge; the partial byte is lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift_q   <= shift_next;
      bit_cnt_q <= bit_cnt_next;
      tx_q      <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_q;
`endif

    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_next = FETCH;
        end
      end

      // The read strobe is out this cycle; fifo_empty may rise now because
      // of our own read, and that no longer matters.
      FETCH: begin
        state_next = LOAD;
      end

      // The FIFO's registered output now holds the strobed byte.
      LOAD: begin
        shift_next   = fifo_rd_data;
        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
        parity_next  = even_parity(fifo_rd_data);
`endif
        state_next   = START;
      end

      START: begin
        if (baud_tick) begin
          state_next = DATA;
        end
      end

      // The LSB of the shift register is always the bit on the line; at each
      // bit boundary shift the next one down. The wrap of the bit counter
      // from its last value ends the payload.
      DATA: begin
        if (baud_tick) begin
          shift_next   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_next = STOP;
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Everything except tx_next is a decode of registered state (plus
  // the registered-counter tick), so none of it depends combinationally on
  // the block's inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_rd_en = (state == FETCH);
    busy       = (state != IDLE);
    tx_done    = (state == STOP) && baud_tick;
    baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

    case (state_next)
      START:   tx_next = ~UART_IDLE_LEVEL;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = UART_IDLE_LEVEL;
    endcase
  end

  assign tx = tx_q;

endmodule : uart_tx_drain

// File: tb/tb_uart_tx_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_drain
//
// Bench for uart_tx_drain at CLKS_PER_BIT = 4. A queue models the byte FIFO
// (one cycle read latency). Each byte the DUT strobes out is pushed as an
// expectation; an independent monitor decodes frames from the tx pin and
// compares them, and their tx_done position, against that expectation.
// Directed sequences cover reset, gating and the boundary cases, then a
// randomized run mixes pushes and enable toggles.
// Build with +define+UART_TX_PARITY_EN to match a parity-enabled DUT.
// -----------------------------------------------------------------------------
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;
  localparam int DRAIN_BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx_drain #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  int   n_checks    = 0;
  int   n_pass      = 0;
  int   n_strobe    = 0;
  int   n_done      = 0;
  int   empty_reads = 0;
  int   gap         = 0;
  int   last_gap    = -1;
  logic rst_at_edge = 1'b0;
  logic mon_active  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame, bit 0 first on the wire.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // FIFO model: a strobe seen at an edge pops a byte onto the read data one
  // step later. A byte popped at an edge where reset is applied never gets
  // framed, so it is not expected.
  initial begin : fifo_model
    logic       rd;
    logic       r;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      rd = fifo_rd_en;
      r  = rst;
      #1;
      rst_at_edge = r;
      if (rd === 1'b1) begin
        n_strobe++;
        if (fifo_q.size() == 0) begin
          empty_reads++;
        end else begin
          b = fifo_q.pop_front();
          fifo_rd_data = b;
          if (!r) exp_q.push_back(b);
        end
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  initial begin : done_counter
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) n_done++;
    end
  end

  // Frame monitor: decodes tx, compares bits, per-bit stability and the
  // tx_done position. A reset drops whatever byte was in flight.
  initial begin : monitor
    logic [7:0]            exp_byte;
    logic [FRAME_BITS-1:0] obs;
    logic                  prev;
    logic                  stable;
    logic                  aborted;
    int                    done_k;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        exp_q.delete();
        gap = 0;
        continue;
      end
      if (tx !== 1'b0) begin
        gap++;
        continue;
      end
      last_gap = gap;
      check("frame_expected", (exp_q.size() != 0), 1);
      exp_byte   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      mon_active = 1'b1;
      obs        = '0;
      prev       = tx;
      stable     = 1'b1;
      aborted    = 1'b0;
      done_k     = 999;
      for (int k = 0; k < FRAME_CYC; k++) begin
        if (k > 0) begin
          @(negedge clk);
          if (rst_at_edge) begin
            aborted = 1'b1;
            exp_q.delete();
            break;
          end
        end
        if (k % CPB == CPB / 2) obs[k / CPB] = tx;
        if (k % CPB != 0 && tx !== prev) stable = 1'b0;
        prev = tx;
        if (tx_done === 1'b1 && done_k == 999) done_k = k;
      end
      mon_active = 1'b0;
      gap = 0;
      if (!aborted) begin
        check($sformatf("frame_bits_%02h", exp_byte), obs, frame_of(exp_byte));
        check($sformatf("bit_stable_%02h", exp_byte), stable, 1);
        check($sformatf("done_cycle_%02h", exp_byte), done_k, FRAME_CYC - 1);
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fifo_q.size() == 0 && !mon_active && busy === 1'b0) && n < DRAIN_BUDGET);
    check({name, "_drained"}, (n < DRAIN_BUDGET), 1);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_frame_started"}, tx, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int   s0;
    int   d0;
    int   cnt;
    logic low_seen;

    // ---- reset: three edges with rst high, data waiting, enable high ----
    enable = 1'b1;
    push_byte(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {tx, fifo_rd_en, busy, tx_done}, 4'b1000);
    end
    rst = 1'b0;
    cnt = 1;
    while (fifo_rd_en !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("first_strobe_cycle", cnt, 2);

    // ---- single byte 0xA5 ----
    wait_drain("single_a5");
    check("single_strobes", n_strobe, 1);
    check("single_dones", n_done, 1);

    // ---- back-to-back 0x00, 0xFF ----
    s0 = n_strobe;
    d0 = n_done;
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_drain("b2b");
    check("b2b_strobes", n_strobe - s0, 2);
    check("b2b_dones", n_done - d0, 2);
    check("b2b_gap", last_gap, 3);

    // ---- single byte 0x07 (odd weight) ----
    push_byte(8'h07);
    wait_drain("single_07");

    // ---- empty FIFO with enable high ----
    s0 = n_strobe;
    low_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check("empty_no_strobe", n_strobe - s0, 0);
    check("empty_tx_low_seen", low_seen, 0);

    // ---- enable low with data waiting ----
    enable = 1'b0;
    push_byte(8'h5A);
    low_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
    end
    check("disabled_no_strobe", n_strobe - s0, 0);
    check("disabled_line_idle", low_seen, 0);
    check("disabled_fifo_kept", fifo_q.size(), 1);
    enable = 1'b1;
    wait_drain("enable_return");
    check("enable_return_strobes", n_strobe - s0, 1);

    // ---- enable dropped mid-frame ----
    s0 = n_strobe;
    push_byte(8'h3C);
    push_byte(8'h11);
    wait_start("midframe");
    enable = 1'b0;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    repeat (20) @(negedge clk);
    check("midframe_strobes", n_strobe - s0, 1);
    check("midframe_fifo_left", fifo_q.size(), 1);
    check("midframe_idle", {busy, tx}, 2'b01);
    enable = 1'b1;
    wait_drain("midframe_flush");

    // ---- reset during DATA bit 3 of 0x81 ----
    s0 = n_strobe;
    push_byte(8'h81);
    push_byte(8'h42);
    wait_start("reset_mid");
    repeat (4 * CPB + 1) @(negedge clk);
    d0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs", {tx, busy, tx_done}, 3'b100);
    rst = 1'b0;
    check("reset_mid_no_done", n_done - d0, 0);
    wait_drain("after_reset");
    check("after_reset_strobes", n_strobe - s0, 2);
    check("after_reset_dones", n_done - d0, 1);

    // ---- randomized pushes and enable toggles ----
    for (int i = 0; i < 24; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    enable = 1'b1;
    wait_drain("random");

    check("no_pending_expect", exp_q.size(), 0);
    check("no_empty_reads", empty_reads, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_drain

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Downstream consumer of the byte FIFO; drains bytes through the FIFO's read port and serialises each one as a UART 8N1 frame on a single tx line.
- Handles the FIFO's registered read latency: read_data is valid on the clock edge after a read strobe.
- Sits between the byte FIFO and the board-level serial pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit period (legal range ≥2).
- DATA_BITS, 8, payload bits per frame; fixed to match the FIFO width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- enable  input  1  permits starting a new frame
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_data  input  8  FIFO read data, valid one cycle after fifo_rd_en
- fifo_rd_en  output  1  FIFO read strobe, one-cycle pulse per byte
- tx  output  1  serial line, idles high
- busy  output  1  high whenever state ≠ IDLE
- tx_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - tx=1, fifo_rd_en=0, busy=0, tx_done=0.
  - state=IDLE; shift register, bit counter and baud counter all 0.
- State machine and transitions:
  - IDLE → FETCH when enable && !fifo_empty; otherwise stay in IDLE.
  - FETCH: fifo_rd_en=1 for exactly this cycle; → LOAD.
  - LOAD: capture fifo_rd_data into the shift register; clear the baud counter; → START.
  - START: tx=0 for CLKS_PER_BIT cycles; → DATA.
  - DATA: tx=shift[0]; on each bit-period end, shift right and increment the bit counter; after 8 bits → STOP (→ PARITY when the optional feature is enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 on the last cycle; → IDLE.
- fifo_rd_en is decoded from state, so exactly one strobe is issued per frame.
- The strobe is issued only after fifo_empty was sampled low; a read is never issued on empty.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. It also resets on entry to START.
- Bit counter: 3 bits; the wrap from 7 marks the end of DATA.
- Frame timing:
  - Frame length is 10*CLKS_PER_BIT cycles from the first START cycle.
  - Inter-frame gap with back-to-back data is 3 cycles of tx=1 (IDLE, FETCH, LOAD).
- tx is registered: no glitches, driven from state/shift register.
- Boundary conditions:
  - enable deasserted mid-frame: the current frame completes; no new FETCH until enable returns.
  - fifo_empty rising after FETCH: ignored; the byte already strobed is sent.
  - fifo_empty and enable both low in IDLE: stay in IDLE, tx=1, no strobe.
  - rst mid-frame: on the next edge, tx=1, state=IDLE, no tx_done. The partial frame is abandoned and the byte is lost.
  - rst in the FETCH cycle: the strobe still occurred that cycle; the byte is dropped.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state or parity logic is compiled.
  - Frame = 10*CLKS_PER_BIT cycles.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP}.
  - localparam DATA_BITS=8.
  - localparam UART_IDLE_LEVEL=1'b1.
- Sub-module baud_tick_gen:
  - Parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick.
  - tick is a one-cycle pulse on the last cycle of each bit period.
  - Reused by the future receiver.

Test Plan:
- Reset: rst high 3 cycles, fifo_empty=0, enable=1 → tx=1, fifo_rd_en=0, busy=0 throughout; first fifo_rd_en 2 cycles after rst falls.
- Single byte: CLKS_PER_BIT=4, FIFO returns 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); tx_done on cycle 40; exactly one fifo_rd_en.
- Back-to-back: FIFO holds 0x00, 0xFF → two frames separated by exactly 3 high cycles; 2 strobes; 2 tx_done pulses.
- Empty/enable gating:
  - fifo_empty=1 with enable=1 for 50 cycles → no strobe, tx=1.
  - enable=0 with fifo_empty=0 → no strobe.
  - enable dropped mid-frame → frame of 0x3C completes, then idle.
- Reset mid-frame: rst pulsed during DATA bit 3 of 0x81 → tx=1 the next cycle, busy=0, no tx_done; the next frame starts cleanly with the next FIFO byte.
- UART_TX_PARITY_EN: 0xA5 → parity bit 0; 0x07 → parity bit 1; frame length 44 cycles at CLKS_PER_BIT=4.
